// File: rtl/pipeline_mem_arbiter_if.sv
// Bus bundle between the two cache controllers, the arbiter and main memory.
// slave  : the arbiter's view (takes requests, drives memory commands).
// master : the caches'/memory model's view.
interface pipeline_mem_arbiter_if #(
  parameter int ADDR_W  = 28,
  parameter int BLOCK_W = 128
);
  logic               I_READ;
  logic [ADDR_W-1:0]  I_ADDRESS;
  logic [BLOCK_W-1:0] I_READDATA;
  logic               I_BUSYWAIT;
  logic               D_READ;
  logic               D_WRITE;
  logic [ADDR_W-1:0]  D_ADDRESS;
  logic [BLOCK_W-1:0] D_WRITEDATA;
  logic [BLOCK_W-1:0] D_READDATA;
  logic               D_BUSYWAIT;
  logic               MEM_READ;
  logic               MEM_WRITE;
  logic [ADDR_W-1:0]  MEM_ADDRESS;
  logic [BLOCK_W-1:0] MEM_WRITEDATA;
  logic [BLOCK_W-1:0] MEM_READDATA;
  logic               MEM_BUSYWAIT;

  modport slave (
    input  I_READ, I_ADDRESS, D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
           MEM_READDATA, MEM_BUSYWAIT,
    output I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
           MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );

  modport master (
    output I_READ, I_ADDRESS, D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
           MEM_READDATA, MEM_BUSYWAIT,
    input  I_READDATA, I_BUSYWAIT, D_READDATA, D_BUSYWAIT,
           MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
  );
endinterface

// File: rtl/pipeline_mem_arbiter.sv
// Shares the single main-memory port between icache and dcache.
// One transaction at a time, sequenced by IDLE/GRANT_I/GRANT_D.
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   -> contested requests alternate between ports (D first after reset)
//   undefined -> dcache always wins contested requests
module pipeline_mem_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int BLOCK_W = 128
) (
  input logic                    CLK,
  input logic                    RESET,
  pipeline_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  state_t             state;
  logic               issued;
  logic               done_i, done_d;
  logic               mem_read, mem_write;
  logic [ADDR_W-1:0]  mem_address;
  logic [BLOCK_W-1:0] mem_writedata;
  logic [BLOCK_W-1:0] i_readdata, d_readdata;

  logic d_req, i_elig, d_elig, pick_d;

  // A port whose done pulse is showing cannot be granted again that cycle,
  // so a request still held during the done cycle is not served twice.
  assign d_req  = bus.D_READ | bus.D_WRITE;
  assign i_elig = bus.I_READ & ~done_i;
  assign d_elig = d_req & ~done_d;

`ifdef ARB_ROUND_ROBIN_EN
  // rr_ptr=1 means I wins the next contested arbitration
  logic rr_ptr;
  assign pick_d = d_elig & (~i_elig | ~rr_ptr);
`else
  assign pick_d = d_elig;
`endif

  assign bus.I_BUSYWAIT    = bus.I_READ & ~done_i;
  assign bus.D_BUSYWAIT    = d_req & ~done_d;
  assign bus.I_READDATA    = i_readdata;
  assign bus.D_READDATA    = d_readdata;
  assign bus.MEM_READ      = mem_read;
  assign bus.MEM_WRITE     = mem_write;
  assign bus.MEM_ADDRESS   = mem_address;
  assign bus.MEM_WRITEDATA = mem_writedata;

  // Grant FSM: latch request on grant, wait for memory, capture and pulse done
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= IDLE;
      issued        <= 1'b0;
      done_i        <= 1'b0;
      done_d        <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      i_readdata    <= '0;
      d_readdata    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr        <= 1'b0;
`endif
    end else begin
      done_i <= 1'b0;
      done_d <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_d) begin
            state         <= GRANT_D;
            mem_address   <= bus.D_ADDRESS;
            mem_writedata <= bus.D_WRITEDATA;
            // read+write together is a write-back; the read comes later
            mem_write     <= bus.D_WRITE;
            mem_read      <= ~bus.D_WRITE;
          end else if (i_elig) begin
            state       <= GRANT_I;
            mem_address <= bus.I_ADDRESS;
            mem_read    <= 1'b1;
            mem_write   <= 1'b0;
          end
`ifdef ARB_ROUND_ROBIN_EN
          if (i_elig && d_elig) rr_ptr <= ~rr_ptr;
`endif
        end
        GRANT_I, GRANT_D: begin
          // first grant cycle ignores MEM_BUSYWAIT: memory has not seen the command yet
          if (!issued) begin
            issued <= 1'b1;
          end else if (!bus.MEM_BUSYWAIT) begin
            issued    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= IDLE;
            if (state == GRANT_I) begin
              i_readdata <= bus.MEM_READDATA;
              done_i     <= 1'b1;
            end else begin
              if (mem_read) d_readdata <= bus.MEM_READDATA;
              done_d <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Directed bench for pipeline_mem_arbiter with a small wait-state memory model.
module tb_pipeline_mem_arbiter;
  localparam int AW = 28;
  localparam int BW = 128;

  localparam logic [BW-1:0] DATA_A  = 128'h0123_4567_89AB_CDEF_0000_1111_2222_CAFE;
  localparam logic [BW-1:0] DATA_B  = 128'hDEAD_BEEF_0BAD_F00D_1357_9BDF_2468_ACE0;
  localparam logic [BW-1:0] DATA_C  = 128'h5555_AAAA_3333_CCCC_0F0F_F0F0_1234_4321;
  localparam logic [BW-1:0] DATA_WB = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
  localparam logic [AW-1:0] IA = 28'h0000040;
  localparam logic [AW-1:0] DA = 28'h0000050;

  logic CLK, RESET;
  pipeline_mem_arbiter_if #(.ADDR_W(AW), .BLOCK_W(BW)) bus ();
  pipeline_mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // memory model: busy for wait_n cycles counted from the command's first cycle
  int            wait_n = 0;
  int            cyc = 0;
  logic [BW-1:0] mem_rdata = '0;
  logic          cmd;
  assign cmd = bus.MEM_READ | bus.MEM_WRITE;
  assign bus.MEM_BUSYWAIT = cmd && (cyc < wait_n);
  assign bus.MEM_READDATA = mem_rdata;

  logic [AW-1:0] wr_addr;
  logic [BW-1:0] wr_data;
  int            wr_cnt = 0;
  int            rd_cyc = 0, wr_cyc = 0, dbw_cyc = 0;

  always @(posedge CLK) begin
    cyc <= cmd ? cyc + 1 : 0;
    if (bus.MEM_WRITE && !bus.MEM_BUSYWAIT && cyc >= 1) begin
      wr_addr <= bus.MEM_ADDRESS;
      wr_data <= bus.MEM_WRITEDATA;
      wr_cnt  <= wr_cnt + 1;
    end
    if (bus.MEM_READ)   rd_cyc  <= rd_cyc + 1;
    if (bus.MEM_WRITE)  wr_cyc  <= wr_cyc + 1;
    if (bus.D_BUSYWAIT) dbw_cyc <= dbw_cyc + 1;
  end

  // grant log: address of every new memory command
  logic [AW-1:0] glog[$];
  logic          prev_cmd = 1'b0;
  always @(negedge CLK) begin
    if (cmd && !prev_cmd) glog.push_back(bus.MEM_ADDRESS);
    prev_cmd = cmd;
  end

  // play both caches: drop a request in its done cycle; j=0 is the cycle after E0
  task automatic serve(output int i_low, output int d_low);
    i_low = -1;
    d_low = -1;
    for (int j = 0; j < 40 && (bus.I_READ || bus.D_READ || bus.D_WRITE); j++) begin
      @(negedge CLK);
      if (bus.I_READ && !bus.I_BUSYWAIT) begin
        i_low = j;
        bus.I_READ = 1'b0;
      end
      if ((bus.D_READ || bus.D_WRITE) && !bus.D_BUSYWAIT) begin
        d_low = j;
        bus.D_READ  = 1'b0;
        bus.D_WRITE = 1'b0;
      end
    end
  endtask

  task automatic clear_stats();
    rd_cyc = 0; wr_cyc = 0; dbw_cyc = 0;
    glog.delete();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    bus.I_READ = 0; bus.I_ADDRESS = '0;
    bus.D_READ = 0; bus.D_WRITE = 0; bus.D_ADDRESS = '0; bus.D_WRITEDATA = '0;
    repeat (2) @(negedge CLK);
    n_chk++; if ({bus.MEM_READ, bus.MEM_WRITE} !== 2'b00) begin n_fail++; $display("FAIL reset_cmd: got %b want 00", {bus.MEM_READ, bus.MEM_WRITE}); end
    n_chk++; if (bus.MEM_ADDRESS !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.MEM_ADDRESS); end
    n_chk++; if (bus.MEM_WRITEDATA !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", bus.MEM_WRITEDATA); end
    n_chk++; if (bus.I_READDATA !== '0 || bus.D_READDATA !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", bus.I_READDATA, bus.D_READDATA); end
    n_chk++; if ({bus.I_BUSYWAIT, bus.D_BUSYWAIT} !== 2'b00) begin n_fail++; $display("FAIL reset_bw: got %b want 00", {bus.I_BUSYWAIT, bus.D_BUSYWAIT}); end
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_lone_i_read();
    int il, dl;
    @(negedge CLK);
    clear_stats();
    wait_n = 4; mem_rdata = DATA_A;
    bus.I_READ = 1'b1; bus.I_ADDRESS = 28'h0000010;
    serve(il, dl);
    n_chk++; if (il !== 5) begin n_fail++; $display("FAIL lone_i_latency: got %0d want 5", il); end
    n_chk++; if (rd_cyc !== 5 || wr_cyc !== 0) begin n_fail++; $display("FAIL lone_i_cmd_cycles: got rd %0d wr %0d want rd 5 wr 0", rd_cyc, wr_cyc); end
    n_chk++; if (bus.I_READDATA !== DATA_A) begin n_fail++; $display("FAIL lone_i_data: got %h want %h", bus.I_READDATA, DATA_A); end
    n_chk++; if (dbw_cyc !== 0) begin n_fail++; $display("FAIL lone_i_dbw: got %0d want 0", dbw_cyc); end
    n_chk++; if (glog.size() !== 1 || bus.MEM_ADDRESS !== 28'h0000010) begin n_fail++; $display("FAIL lone_i_addr: got %0d grants addr %h want 1 grant addr 0000010", glog.size(), bus.MEM_ADDRESS); end
    @(negedge CLK);
    n_chk++; if (bus.MEM_READ !== 1'b0) begin n_fail++; $display("FAIL lone_i_no_regrant: got %b want 0", bus.MEM_READ); end
  endtask

  task automatic test_back_to_back();
    int il, dl;
    @(negedge CLK);
    clear_stats();
    wait_n = 0; mem_rdata = DATA_A;
    bus.D_READ = 1'b1; bus.D_ADDRESS = 28'h0000030;
    repeat (3) @(negedge CLK);
    n_chk++; if (bus.D_BUSYWAIT !== 1'b0 || bus.D_READDATA !== DATA_A) begin n_fail++; $display("FAIL b2b_first: got bw %b data %h want 0 %h", bus.D_BUSYWAIT, bus.D_READDATA, DATA_A); end
    bus.D_ADDRESS = 28'h0000031; mem_rdata = DATA_B;
    @(negedge CLK);
    n_chk++; if (bus.MEM_READ !== 1'b0 || bus.D_BUSYWAIT !== 1'b1) begin n_fail++; $display("FAIL b2b_done_mask: got rd %b bw %b want 0 1", bus.MEM_READ, bus.D_BUSYWAIT); end
    @(negedge CLK);
    n_chk++; if (bus.MEM_READ !== 1'b1 || bus.MEM_ADDRESS !== 28'h0000031) begin n_fail++; $display("FAIL b2b_regrant: got rd %b addr %h want 1 0000031", bus.MEM_READ, bus.MEM_ADDRESS); end
    serve(il, dl);
    n_chk++; if (dl !== 1 || bus.D_READDATA !== DATA_B) begin n_fail++; $display("FAIL b2b_second: got low %0d data %h want 1 %h", dl, bus.D_READDATA, DATA_B); end
    mem_rdata = DATA_C;
    @(negedge CLK);
    n_chk++; if (bus.D_READDATA !== DATA_B) begin n_fail++; $display("FAIL b2b_hold: got %h want %h", bus.D_READDATA, DATA_B); end
  endtask

  task automatic test_d_writeback();
    int il, dl, wc0;
    @(negedge CLK);
    clear_stats();
    wc0 = wr_cnt;
    wait_n = 0;
    bus.D_WRITE = 1'b1; bus.D_ADDRESS = 28'h00000A0; bus.D_WRITEDATA = DATA_WB;
    serve(il, dl);
    n_chk++; if (dl !== 2) begin n_fail++; $display("FAIL wb_latency: got %0d want 2", dl); end
    n_chk++; if (wr_cyc !== 2 || rd_cyc !== 0) begin n_fail++; $display("FAIL wb_cmd_cycles: got wr %0d rd %0d want wr 2 rd 0", wr_cyc, rd_cyc); end
    n_chk++; if (wr_cnt !== wc0 + 1 || wr_addr !== 28'h00000A0 || wr_data !== DATA_WB) begin n_fail++; $display("FAIL wb_mem: got n %0d addr %h data %h want n %0d addr 00000a0 data %h", wr_cnt - wc0, wr_addr, wr_data, 1, DATA_WB); end
    n_chk++; if (bus.D_READDATA !== DATA_B) begin n_fail++; $display("FAIL wb_rdata_hold: got %h want %h", bus.D_READDATA, DATA_B); end
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  task automatic test_contested_rr();
    int il, dl;
    int exp_il[3] = '{5, 2, 5};
    int exp_dl[3] = '{2, 5, 2};
    logic [AW-1:0] exp_g[6] = '{DA, IA, IA, DA, DA, IA};
    @(negedge CLK);
    clear_stats();
    wait_n = 1;
    for (int p = 0; p < 3; p++) begin
      @(negedge CLK);
      bus.I_READ = 1'b1; bus.I_ADDRESS = IA;
      bus.D_READ = 1'b1; bus.D_ADDRESS = DA;
      serve(il, dl);
      n_chk++; if (il !== exp_il[p] || dl !== exp_dl[p]) begin n_fail++; $display("FAIL rr_pair%0d: got i %0d d %0d want i %0d d %0d", p, il, dl, exp_il[p], exp_dl[p]); end
    end
    n_chk++; if (glog.size() !== 6) begin n_fail++; $display("FAIL rr_grants: got %0d want 6", glog.size()); end
    for (int g = 0; g < 6 && g < glog.size(); g++) begin
      n_chk++; if (glog[g] !== exp_g[g]) begin n_fail++; $display("FAIL rr_order%0d: got %h want %h", g, glog[g], exp_g[g]); end
    end
  endtask
`else
  task automatic test_contested_fixed();
    int il, dl;
    @(negedge CLK);
    clear_stats();
    wait_n = 1;
    bus.I_READ = 1'b1; bus.I_ADDRESS = IA;
    bus.D_READ = 1'b1; bus.D_ADDRESS = DA;
    serve(il, dl);
    n_chk++; if (dl !== 2 || il !== 5) begin n_fail++; $display("FAIL fixed_latency: got d %0d i %0d want d 2 i 5", dl, il); end
    n_chk++; if (glog.size() !== 2) begin n_fail++; $display("FAIL fixed_grants: got %0d want 2", glog.size()); end
    else if (glog[0] !== DA || glog[1] !== IA) begin n_fail++; $display("FAIL fixed_order: got %h,%h want %h,%h", glog[0], glog[1], DA, IA); end
  endtask
`endif

  task automatic test_reset_mid_grant();
    int il, dl;
    @(negedge CLK);
    clear_stats();
    wait_n = 10; mem_rdata = DATA_C;
    bus.D_READ = 1'b1; bus.D_ADDRESS = 28'h0000060;
    repeat (3) @(negedge CLK);
    n_chk++; if (bus.MEM_READ !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got %b want 1", bus.MEM_READ); end
    #2 RESET = 1'b1;
    #1;
    n_chk++; if (bus.MEM_READ !== 1'b0 || bus.MEM_WRITE !== 1'b0 || bus.MEM_ADDRESS !== '0) begin n_fail++; $display("FAIL rst_mid_abort: got rd %b wr %b addr %h want 0 0 0", bus.MEM_READ, bus.MEM_WRITE, bus.MEM_ADDRESS); end
    n_chk++; if (bus.D_READDATA !== '0 || bus.I_READDATA !== '0) begin n_fail++; $display("FAIL rst_mid_rdata: got %h/%h want 0/0", bus.D_READDATA, bus.I_READDATA); end
    n_chk++; if (bus.D_BUSYWAIT !== 1'b1) begin n_fail++; $display("FAIL rst_mid_bw: got %b want 1", bus.D_BUSYWAIT); end
    @(negedge CLK);
    RESET = 1'b0; wait_n = 0;
    serve(il, dl);
    n_chk++; if (dl !== 2 || bus.D_READDATA !== DATA_C) begin n_fail++; $display("FAIL rst_mid_regrant: got low %0d data %h want 2 %h", dl, bus.D_READDATA, DATA_C); end
    n_chk++; if (glog.size() !== 2 || glog[glog.size()-1] !== 28'h0000060) begin n_fail++; $display("FAIL rst_mid_grants: got %0d grants want 2 to 0000060", glog.size()); end
  endtask

  initial begin
    test_reset();
    test_lone_i_read();
    test_back_to_back();
    test_d_writeback();
`ifdef ARB_ROUND_ROBIN_EN
    test_contested_rr();
`else
    test_contested_fixed();
`endif
    test_reset_mid_grant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_mem_arbiter.md
# pipeline_mem_arbiter

Shares one block-wide main memory port between the instruction cache and the data cache of the RV32IM pipeline. Requests are granted one at a time and sequenced through a small FSM. Each cache sees a BUSYWAIT, which it forwards to the pipeline registers' BUSYWAIT inputs to freeze the pipeline. The arbiter sits between the two cache controllers and the main memory model.

## Interface
- ADDR_W, 28: block address width (32-bit byte address minus 4 offset bits)
- BLOCK_W, 128: data block width in bits
- CLK  in  1  system clock; all state changes on rising edge
- RESET  in  1  asynchronous, active-high reset
- I_READ  in  1  icache block-read request; held until I_BUSYWAIT low
- I_ADDRESS  in  ADDR_W  icache block address
- I_READDATA  out  BLOCK_W  block returned to icache
- I_BUSYWAIT  out  1  icache must wait
- D_READ  in  1  dcache block-read request
- D_WRITE  in  1  dcache block-write (write-back) request
- D_ADDRESS  in  ADDR_W  dcache block address
- D_WRITEDATA  in  BLOCK_W  block to write
- D_READDATA  out  BLOCK_W  block returned to dcache
- D_BUSYWAIT  out  1  dcache must wait
- MEM_READ  out  1  memory read command
- MEM_WRITE  out  1  memory write command
- MEM_ADDRESS  out  ADDR_W  memory block address
- MEM_WRITEDATA  out  BLOCK_W  memory write data
- MEM_READDATA  in  BLOCK_W  memory read data
- MEM_BUSYWAIT  in  1  memory busy; low marks completion

## Operation
- States: IDLE, GRANT_I, GRANT_D.
- IDLE: a request is eligible if it is asserted and not masked by the done pulse.
  - Only I eligible → GRANT_I.
  - Only D eligible → GRANT_D.
  - Both eligible → winner per Configuration.
  - None → stay in IDLE.
- Entering a grant state latches address, command and write data into internal registers. MEM_* are driven from these registers, never directly from the requester inputs.
- D_READ and D_WRITE both high: treated as write. A dcache read that follows needs a separate request.
- Grant states:
  - First cycle: sets internal issued flag; MEM_BUSYWAIT ignored.
  - Each later edge with MEM_BUSYWAIT=0: transaction completes. On a read, capture MEM_READDATA into that port's READDATA register. Clear MEM_READ/MEM_WRITE, return to IDLE, pulse done_I or done_D for one cycle.
- X_BUSYWAIT = (X request asserted) AND NOT done_X. BUSYWAIT is therefore high from the request cycle until the done cycle, including while the other port owns memory.
- During done_X, port X is ineligible. The requester drops or changes its request in that cycle; no double grant of the same request.
- I_READDATA/D_READDATA hold their value until that port's next read completion.
- Dropping a request while granted is illegal. The arbiter still finishes the memory transaction.

## Timing
- Reset (async, immediate) drives:
  - state IDLE; issued, done_I, done_D, priority pointer = 0
  - MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA = 0
  - I_READDATA, D_READDATA = 0
  - BUSYWAITs follow their formula, so they are high if a request is present.
- Reset mid-transaction aborts the memory command at once; no data is captured. Requests still asserted after release are re-arbitrated from IDLE.
- Request sampled at edge E0 → MEM_* valid after E0 → E1 sets issued → completion at the first edge Ek (k≥2) with MEM_BUSYWAIT=0 → done pulse in cycle Ek..Ek+1.
- Minimum latency: 2 cycles from the sampling edge to READDATA valid and BUSYWAIT low, with zero-wait memory.
- Back-to-back: the next grant is sampled at Ek+1, so memory has at least one idle cycle between transactions.
- MEM_ADDRESS/MEM_WRITEDATA stay stable for the whole grant.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - On a simultaneous I/D request, the port that did not win the last contested arbitration wins.
  - The pointer toggles only on contested arbitrations; after reset, D wins first.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, D always wins contested arbitrations. No pointer register exists.

## Test plan
- Lone I read: I_READ=1, I_ADDRESS=0x0000010, memory busy 4 cycles, returns 0x...CAFE → MEM_READ only in GRANT_I, I_READDATA=0x...CAFE, I_BUSYWAIT low for exactly one cycle, D_BUSYWAIT stays 0.
- D write-back: D_WRITE=1, D_ADDRESS=0x00000A0, D_WRITEDATA=0x1234…; zero-wait memory → MEM_WRITE high for 2 cycles, D_READDATA unchanged, D_BUSYWAIT low 2 cycles after request.
- Contested, fixed priority (macro off): I_READ and D_READ rise at the same edge → D served first, I granted at Ek+1, I_BUSYWAIT high throughout D transaction.
- Contested, round-robin (macro on): three consecutive simultaneous I/D pairs → grant order D, I, I, D, D, I.
- Reset mid-grant: assert RESET while in GRANT_D with MEM_BUSYWAIT=1 → MEM_WRITE/MEM_READ drop in same cycle, D_READDATA=0, re-grant after release.
- Zero-wait back-to-back: D request re-asserted during done_D → not re-granted in the done cycle; second grant at the following edge.
